// File: rtl/stack_seq_pkg.sv
// Shared types and defaults for the 6502 stack access sequencer.
package stack_seq_pkg;

  localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;
  localparam int         MAX_BYTES_DEFAULT  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef enum logic {
    DIR_PUSH = 1'b0,
    DIR_PULL = 1'b1
  } dir_t;

  typedef logic [1:0] byte_count_t;

endpackage

// File: rtl/stack_ptr_step.sv
// Wrap-around +/-1 generator for the 8-bit stack pointer.
module stack_ptr_step
  import stack_seq_pkg::*;
(
  input  logic [7:0] ptr,
  input  dir_t       dir,
  output logic [7:0] ptr_dec,
  output logic [7:0] ptr_inc,
  output logic [7:0] access_ptr
);

  assign ptr_dec = ptr - 8'd1;
  assign ptr_inc = ptr + 8'd1;
  // S points at the next free slot, so a pull touches the byte above it.
  assign access_ptr = (dir == DIR_PULL) ? ptr_inc : ptr;

endmodule

// File: rtl/stack_access_sequencer.sv
// Sequences 1..MAX_BYTES page-one stack accesses per operation and
// returns the updated stack pointer with a one-cycle load pulse.
module stack_access_sequencer
  import stack_seq_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT,
  parameter int         MAX_BYTES  = MAX_BYTES_DEFAULT
) (
  input  logic                   phi2,
  input  logic                   reset,
  input  logic [7:0]             sp_in,
  input  logic                   op_start,
  input  logic                   op_dir,
  input  logic [1:0]             op_count,
  input  logic [MAX_BYTES*8-1:0] push_data,
  input  logic [7:0]             mem_rdata,
  input  logic                   mem_ready,
  output logic [15:0]            mem_addr,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic [7:0]             mem_wdata,
  output logic [MAX_BYTES*8-1:0] pull_data,
  output logic [7:0]             sp_out,
  output logic                   sp_load,
  output logic                   busy,
  output logic                   done
);

  state_t      state;
  state_t      next_state;
  logic [7:0]  ptr;
  dir_t        dir_q;
  byte_count_t count_q;
  byte_count_t idx;
  logic [7:0]  sp_q;
  logic [7:0]  push_bytes [MAX_BYTES];
  logic [7:0]  pull_bytes [MAX_BYTES];

  logic [7:0]  ptr_dec;
  logic [7:0]  ptr_inc;
  logic [7:0]  access_ptr;
  logic [7:0]  next_ptr;
  logic        count_valid;
  logic        last_byte;
  logic        in_xfer;

  stack_ptr_step u_step (
    .ptr        (ptr),
    .dir        (dir_q),
    .ptr_dec    (ptr_dec),
    .ptr_inc    (ptr_inc),
    .access_ptr (access_ptr)
  );

  assign next_ptr    = (dir_q == DIR_PULL) ? ptr_inc : ptr_dec;
  assign count_valid = (op_count != 2'd0) && (32'(op_count) <= MAX_BYTES);
  assign last_byte   = (idx == (count_q - 2'd1));
  assign in_xfer     = (state == XFER);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (op_start && count_valid) next_state = XFER;
      XFER:    if (mem_ready && last_byte) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= 8'h00;
      dir_q   <= DIR_PUSH;
      count_q <= 2'd0;
      idx     <= 2'd0;
      sp_q    <= 8'h00;
      for (int i = 0; i < MAX_BYTES; i++) begin
        push_bytes[i] <= 8'h00;
        pull_bytes[i] <= 8'h00;
      end
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (op_start && count_valid) begin
            ptr     <= sp_in;
            dir_q   <= dir_t'(op_dir);
            count_q <= op_count;
            idx     <= 2'd0;
            for (int i = 0; i < MAX_BYTES; i++) begin
              push_bytes[i] <= push_data[8*i +: 8];
              pull_bytes[i] <= 8'h00;
            end
          end
        end
        XFER: begin
          if (mem_ready) begin
            ptr <= next_ptr;
            idx <= idx + 2'd1;
            if (dir_q == DIR_PULL) pull_bytes[idx] <= mem_rdata;
            // Captured on the final access so sp_out is already valid alongside sp_load.
            if (last_byte) sp_q <= next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rd    = in_xfer && (dir_q == DIR_PULL);
    mem_wr    = in_xfer && (dir_q == DIR_PUSH);
    mem_addr  = in_xfer ? {STACK_PAGE, access_ptr} : 16'h0000;
    mem_wdata = mem_wr ? push_bytes[idx] : 8'h00;
    pull_data = '0;
    for (int i = 0; i < MAX_BYTES; i++) pull_data[8*i +: 8] = pull_bytes[i];
  end

  assign busy    = (state != IDLE);
  assign done    = (state == FINISH);
  assign sp_load = (state == FINISH);
  assign sp_out  = sp_q;

endmodule
